// File: rtl/fpu_pkg.sv
// Shared constants and types for the fpu adder and its operand feeder.
// Word format: {sign, exp[5:0] biased by 31, mant[24:0]}.
package fpu_pkg;

    localparam int FPU_LAT = 5;
    localparam int EXP_W   = 6;
    localparam int MANT_W  = 25;
    localparam int BIAS    = 31;

    localparam logic [3:0] STAT_EXACT     = 4'd0;
    localparam logic [3:0] STAT_INEXACT   = 4'd1;
    localparam logic [3:0] STAT_OVERFLOW  = 4'd2;
    localparam logic [3:0] STAT_UNDERFLOW = 4'd3;

    typedef logic [$clog2(FPU_LAT)-1:0] phase_t;

    typedef struct packed {
        logic [31:0] op_a;
        logic [31:0] op_b;
    } op_pair_t;

    function automatic logic is_range_err(input logic [3:0] st);
        return (st == STAT_OVERFLOW) || (st == STAT_UNDERFLOW);
    endfunction

endpackage

// File: rtl/fpu_op_fifo.sv
// Operand-pair FIFO for the fpu feeder; pointers wrap mod DEPTH (power of 2).
// Push is refused when full, even if a pop happens on the same edge.
module fpu_op_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  op_pair_t                 wdata,
    input  logic                     pop,
    output op_pair_t                 rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    op_pair_t       r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_push;
    logic           w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign rdata  = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fpu_op_feeder.sv
// Issue/collect stage for the free-running 5-state fpu adder: one op in flight, results in order.
// Optional FPU_FEEDER_STATS_EN adds a saturating overflow/underflow result counter.
module fpu_op_feeder #(
    parameter int DEPTH   = 4,
    parameter int FPU_LAT = fpu_pkg::FPU_LAT
) (
    input  logic        clock100KHz,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_op_A,
    input  logic [31:0] in_op_B,
    output logic [31:0] fpu_op_A,
    output logic [31:0] fpu_op_B,
    input  logic [31:0] fpu_data,
    input  logic [3:0]  fpu_status,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [3:0]  res_status,
    output logic [15:0] ovf_cnt
);

    import fpu_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    phase_t         r_phase;
    logic           r_inflight;
    logic           r_sampled;
    logic           r_res_valid;
    logic [31:0]    r_res_data;
    logic [3:0]     r_res_status;
    logic [31:0]    r_op_a;
    logic [31:0]    r_op_b;

    op_pair_t       w_head;
    logic           w_full;
    logic           w_empty;
    logic [CW-1:0]  w_count;
    logic           w_last;
    logic           w_first;
    logic           w_slot_free;
    logic           w_load;
    logic           w_capture;

    fpu_op_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clock100KHz),
        .rst   (reset),
        .push  (in_valid && !w_full),
        .wdata ('{op_a: in_op_A, op_b: in_op_B}),
        .pop   (w_load),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign w_last      = (r_phase == phase_t'(FPU_LAT-1));
    assign w_first     = (r_phase == '0);
    // Slot must be empty or draining now: the capture is the only writer and comes 6 edges later.
    assign w_slot_free = !r_res_valid || res_ready;
    assign w_load      = w_last && !w_empty && !r_inflight && w_slot_free;
    assign w_capture   = w_first && r_inflight && r_sampled;

    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            r_phase      <= '0;
            r_inflight   <= 1'b0;
            r_sampled    <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_status <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
        end else begin
            r_phase <= w_last ? '0 : r_phase + 1'b1;
            if (w_load) begin
                r_op_a     <= w_head.op_a;
                r_op_b     <= w_head.op_b;
                r_inflight <= 1'b1;
                r_sampled  <= 1'b0;
            end
            if (w_first && r_inflight && !r_sampled) r_sampled <= 1'b1;
            if (w_capture) begin
                r_res_data   <= fpu_data;
                r_res_status <= fpu_status;
                r_res_valid  <= 1'b1;
                r_inflight   <= 1'b0;
                r_sampled    <= 1'b0;
            end else if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

`ifdef FPU_FEEDER_STATS_EN
    logic [15:0] r_ovf_cnt;

    always_ff @(posedge clock100KHz or posedge reset) begin
        if (reset) begin
            r_ovf_cnt <= '0;
        end else if (w_capture && is_range_err(fpu_status) && (r_ovf_cnt != 16'hFFFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`else
    assign ovf_cnt = '0;
`endif

    assign in_ready   = (w_count != CW'(DEPTH));
    assign fpu_op_A   = r_op_a;
    assign fpu_op_B   = r_op_b;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_status = r_res_status;

endmodule

// File: tb/tb_fpu_op_feeder.sv
// Scoreboard bench for fpu_op_feeder with a table-driven stand-in for the 5-state fpu.
// Honours FPU_FEEDER_STATS_EN for the ovf_cnt expectation.
module tb_fpu_op_feeder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_op_A;
    logic [31:0] in_op_B;
    logic [31:0] fpu_op_A;
    logic [31:0] fpu_op_B;
    logic [31:0] fpu_data;
    logic [3:0]  fpu_status;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_status;
    logic [15:0] ovf_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [31:0] vd [8];
    logic [3:0]  vs [8];

    logic [35:0] exp_q [$];
    logic [35:0] mon_e;
    logic [2:0]  tb_ph;

    fpu_op_feeder #(.DEPTH(4), .FPU_LAT(5)) dut (
        .clock100KHz (clk),
        .reset       (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op_A     (in_op_A),
        .in_op_B     (in_op_B),
        .fpu_op_A    (fpu_op_A),
        .fpu_op_B    (fpu_op_B),
        .fpu_data    (fpu_data),
        .fpu_status  (fpu_status),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_status  (res_status),
        .ovf_cnt     (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [35:0] fpu_ref(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 8; i++)
            if (va[i] == a && vb[i] == b) return {vd[i], vs[i]};
        return {32'hBAD0_0000, 4'd1};
    endfunction

    // fpu stand-in: samples operands on the edge leaving MOD_EXPO, result held for the round
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tb_ph      <= 3'd0;
            fpu_data   <= 32'd0;
            fpu_status <= 4'd0;
        end else begin
            tb_ph <= (tb_ph == 3'd4) ? 3'd0 : tb_ph + 3'd1;
            if (tb_ph == 3'd0) {fpu_data, fpu_status} <= fpu_ref(fpu_op_A, fpu_op_B);
        end
    end

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out", nm);
    endtask

    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h/%0d expected none", res_data, res_status);
            end else begin
                mon_e = exp_q.pop_front();
                chk("res_data", 36'(res_data), 36'(mon_e[35:4]));
                chk("res_status", 36'(res_status), 36'(mon_e[3:0]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int idx);
        in_op_A  = va[idx];
        in_op_B  = vb[idx];
        in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if (in_ready) begin
                tick(1);
                in_valid = 1'b0;
                exp_q.push_back({vd[idx], vs[idx]});
                return;
            end
            tick(1);
        end
        in_valid = 1'b0;
        timeout("push");
    endtask

    task automatic wait_valid();
        for (int t = 0; t < 100; t++) begin
            if (res_valid) return;
            tick(1);
        end
        timeout("wait_valid");
    endtask

    task automatic drain();
        for (int t = 0; t < 400; t++) begin
            if (exp_q.size() == 0 && !res_valid) return;
            tick(1);
        end
        timeout("drain");
    endtask

    task automatic wait_phase(input logic [2:0] ph);
        for (int t = 0; t < 10; t++) begin
            if (tb_ph == ph) return;
            tick(1);
        end
        timeout("wait_phase");
    endtask

    // push at phase 2: load on the phase-4 edge (2 edges), result valid 6 edges after load
    task automatic lat_test(input int idx);
        int lat;
        wait_phase(3'd2);
        in_op_A  = va[idx];
        in_op_B  = vb[idx];
        in_valid = 1'b1;
        chk("in_ready_free", 36'(in_ready), 36'd1);
        tick(1);
        in_valid = 1'b0;
        exp_q.push_back({vd[idx], vs[idx]});
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            tick(1);
            if (n == 2) chk("load_op_A", 36'(fpu_op_A), 36'(va[idx]));
            if (res_valid) begin
                lat = n;
                break;
            end
        end
        chk("latency", 36'(lat), 36'd8);
    endtask

    initial begin
        logic seen;
        logic [15:0] exp_ovf;
        va[0] = 32'h3E000000; vb[0] = 32'h3E000000; vd[0] = 32'h40000000; vs[0] = 4'd0; // 1+1=2
        va[1] = 32'h3E000000; vb[1] = 32'h40000000; vd[1] = 32'h41000000; vs[1] = 4'd0; // 1+2=3
        va[2] = 32'h40000000; vb[2] = 32'h40000000; vd[2] = 32'h42000000; vs[2] = 4'd0; // 2+2=4
        va[3] = 32'h3F000000; vb[3] = 32'h3E000000; vd[3] = 32'h40800000; vs[3] = 4'd0; // 1.5+1=2.5
        va[4] = 32'h7FFFFFFF; vb[4] = 32'h7FFFFFFF; vd[4] = 32'h7FFFFFFF; vs[4] = 4'd2; // overflow
        va[5] = 32'h00000001; vb[5] = 32'h00000001; vd[5] = 32'h00000000; vs[5] = 4'd3; // underflow
        va[6] = 32'hBE000000; vb[6] = 32'h3F000000; vd[6] = 32'h3C000000; vs[6] = 4'd0; // -1+1.5=0.5
        va[7] = 32'h3E000000; vb[7] = 32'hBE000000; vd[7] = 32'h00000000; vs[7] = 4'd0; // 1-1=0

        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b1; in_op_A = '0; in_op_B = '0;
        tick(2);
        chk("rst_in_ready", 36'(in_ready), 36'd1);
        chk("rst_res_valid", 36'(res_valid), 36'd0);
        chk("rst_fpu_op_A", 36'(fpu_op_A), 36'd0);
        chk("rst_res_data", 36'(res_data), 36'd0);
        chk("rst_ovf_cnt", 36'(ovf_cnt), 36'd0);
        rst = 1'b0;

        // 1) single op latency
        lat_test(0);
        drain();

        // 2) fill FIFO behind a held result, fifth offer refused
        res_ready = 1'b0;
        push(1);
        wait_valid();
        push(2); push(3); push(6); push(7);
        chk("full_in_ready", 36'(in_ready), 36'd0);
        in_op_A = va[0]; in_op_B = vb[0]; in_valid = 1'b1;
        tick(6);
        chk("full_hold_in_ready", 36'(in_ready), 36'd0);
        in_valid = 1'b0;
        res_ready = 1'b1;
        drain();

        // 3) held result blocks the next load until a res_ready pulse on the load edge
        res_ready = 1'b0;
        push(0); push(3);
        wait_valid();
        tick(12);
        chk("blocked_op_A", 36'(fpu_op_A), 36'(va[0]));
        wait_phase(3'd4);
        res_ready = 1'b1;
        tick(1);
        res_ready = 1'b0;
        chk("pulse_res_valid", 36'(res_valid), 36'd0);
        chk("pulse_load_op_A", 36'(fpu_op_A), 36'(va[3]));
        wait_valid();
        res_ready = 1'b1;
        drain();

        // 4) range errors
        push(4); push(5);
        drain();
`ifdef FPU_FEEDER_STATS_EN
        exp_ovf = 16'd2;
`else
        exp_ovf = 16'd0;
`endif
        chk("ovf_cnt", 36'(ovf_cnt), 36'(exp_ovf));

        // 5) reset with one op in flight and one queued
        push(1); push(2);
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            if (fpu_op_A == va[1]) seen = 1'b1;
            else tick(1);
        end
        if (!seen) timeout("wait_load");
        tick(3);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_res_valid", 36'(res_valid), 36'd0);
        chk("mid_rst_in_ready", 36'(in_ready), 36'd1);
        chk("mid_rst_ovf_cnt", 36'(ovf_cnt), 36'd0);
        tick(2);
        rst = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 15; t++) begin
            if (res_valid) seen = 1'b1;
            tick(1);
        end
        chk("no_result_after_reset", 36'(seen), 36'd0);
        lat_test(6);
        drain();

        // 6) consumer frees the slot on the same edge the next op loads
        res_ready = 1'b0;
        push(7); push(2);
        wait_valid();
        wait_phase(3'd4);
        res_ready = 1'b1;
        drain();
        chk("final_ovf_cnt", 36'(ovf_cnt), 36'd0);
        chk("final_in_ready", 36'(in_ready), 36'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
